// File: rtl/int_apx_pkg.sv
// Shared definitions for the integer-adder operand sequencer: state encoding and
// the default datapath width.
package int_apx_pkg;

    localparam int DATA_PATH_BITWIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_GET_A   = 2'd0,
        ST_GET_B   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_HOLD    = 2'd3
    } seq_state_e;

endpackage : int_apx_pkg

// File: rtl/int_add_operand_sequencer.sv
// Pairs an input word stream into adder operands A/B, holds reg_en for a fixed
// settle window, samples the sum and hands {a, b, c} downstream over valid/ready.
module int_add_operand_sequencer
    import int_apx_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = DATA_PATH_BITWIDTH_DEFAULT,
    parameter int SETTLE_CYCLES      = 4,
    parameter int CNT_W              = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] add_a,
    output logic [DATA_PATH_BITWIDTH-1:0] add_b,
    output logic                          add_reg_en,
    input  logic [DATA_PATH_BITWIDTH-1:0] add_c,
    output logic [DATA_PATH_BITWIDTH-1:0] out_a,
    output logic [DATA_PATH_BITWIDTH-1:0] out_b,
    output logic [DATA_PATH_BITWIDTH-1:0] out_c,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_W-1:0]              pair_count,
    output logic                          busy
);

    localparam int                SET_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    seq_state_e                    state_q,      state_d;
    logic [SET_W-1:0]              settle_cnt_q, settle_cnt_d;
    logic [DATA_PATH_BITWIDTH-1:0] add_a_q,      add_a_d;
    logic [DATA_PATH_BITWIDTH-1:0] add_b_q,      add_b_d;
    logic [DATA_PATH_BITWIDTH-1:0] out_a_q,      out_a_d;
    logic [DATA_PATH_BITWIDTH-1:0] out_b_q,      out_b_d;
    logic [DATA_PATH_BITWIDTH-1:0] out_c_q,      out_c_d;
    logic                          out_valid_q,  out_valid_d;
    logic                          in_ready_q,   in_ready_d;
    logic                          reg_en_q,     reg_en_d;
    logic                          busy_q,       busy_d;
    logic [CNT_W-1:0]              pair_cnt_q,   pair_cnt_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_c_d      = out_c_q;
        out_valid_d  = out_valid_q;
        pair_cnt_d   = pair_cnt_q;

        // Acceptance uses the registered in_ready so nothing is taken in the
        // first cycle after reset release, while in_ready is still low.
        case (state_q)
            ST_GET_A: begin
                if (in_valid && in_ready_q) begin
                    add_a_d = in_data;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (in_valid && in_ready_q) begin
                    add_b_d      = in_data;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    out_a_d     = add_a_q;
                    out_b_d     = add_b_q;
                    out_c_d     = add_c;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    pair_cnt_d  = pair_cnt_q + CNT_W'(1);
                    state_d     = ST_GET_A;
                end
            end
            default: state_d = ST_GET_A;
        endcase

        // Control outputs are registered from the next state so they align with it.
        in_ready_d = (state_d == ST_GET_A) || (state_d == ST_GET_B);
        reg_en_d   = (state_d == ST_SETTLE);
        busy_d     = (state_d != ST_GET_A);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_GET_A;
            settle_cnt_q <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_c_q      <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            reg_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            pair_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_c_q      <= out_c_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            reg_en_q     <= reg_en_d;
            busy_q       <= busy_d;
            pair_cnt_q   <= pair_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_reg_en = reg_en_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_c      = out_c_q;
    assign out_valid  = out_valid_q;
    assign pair_count = pair_cnt_q;
    assign busy       = busy_q;

endmodule : int_add_operand_sequencer

// File: doc/int_add_operand_sequencer.md
# int_add_operand_sequencer

Upstream control stage for the configurable clock-gated integer adder (`config_int_add_clkGate`).
- Accepts a stream of DATA_PATH_BITWIDTH-bit words over valid/ready and pairs them as operand A then operand B.
- Drives the adder's `a`, `b` and `reg_en`, waits a fixed settle window, samples `c`, and emits {a, b, c} downstream over valid/ready.
- Replaces hand-timed operand holding in benches and system wrappers with a cycle-exact, backpressure-aware handshake.

## Interface

Parameters:
- DATA_PATH_BITWIDTH, 32, width of operands and result
- SETTLE_CYCLES, 4, cycles `add_reg_en` is held high before `add_c` is sampled; legal range 1..255
- CNT_W, 16, width of the pair counter

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_data  in  DATA_PATH_BITWIDTH  operand word
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts a word this cycle
- add_a  out  DATA_PATH_BITWIDTH  to adder `a`
- add_b  out  DATA_PATH_BITWIDTH  to adder `b`
- add_reg_en  out  1  to adder `reg_en`
- add_c  in  DATA_PATH_BITWIDTH  from adder `c`
- out_a, out_b, out_c  out  DATA_PATH_BITWIDTH each  captured operand pair and result
- out_valid  out  1  result triple valid
- out_ready  in  1  downstream accepts the triple
- pair_count  out  CNT_W  completed output handshakes, wraps modulo 2^CNT_W
- busy  out  1  high in any state other than GET_A

## Operation

- The FSM states are GET_A, GET_B, SETTLE, HOLD.
- GET_A:
  - in_ready=1.
  - On in_valid: latch in_data into add_a and go to GET_B.
- GET_B:
  - in_ready=1.
  - On in_valid: latch in_data into add_b, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE:
  - in_ready=0, add_reg_en=1.
  - The counter decrements each cycle.
  - When the counter is 0: capture add_c into out_c, copy add_a/add_b into out_a/out_b, set out_valid, and go to HOLD.
- HOLD:
  - in_ready=0, add_reg_en=0.
  - out_* and out_valid are held stable until out_valid & out_ready.
  - On that handshake: clear out_valid, increment pair_count, and go to GET_A.
- add_a and add_b hold their last values outside their load states. The adder inputs never change while add_reg_en=1.
- No pipelining: at most one pair is in flight.
- Data is treated as raw bits; there is no sign interpretation and no arithmetic inside the sequencer.
- While rst is low:
  - State is GET_A.
  - All data outputs, pair_count and the counter are 0.
  - in_ready, add_reg_en, out_valid and busy are 0. in_ready is gated low during reset.
- Reset asserted mid-operation (any state) aborts the pair immediately. No output triple is emitted for it, and the adder is left with add_reg_en=0.

## Timing

- Cycle k: word A accepted.
- Cycle k+1: in_ready=1 in GET_B. If in_valid is already high, B is accepted in k+1.
- With B accepted in cycle m:
  - add_reg_en is high in cycles m+1 .. m+SETTLE_CYCLES.
  - add_c is sampled at the end of cycle m+SETTLE_CYCLES.
  - out_valid is high from cycle m+SETTLE_CYCLES+1.
- If out_ready is high in the first HOLD cycle, the handshake completes that cycle and in_ready returns in the next cycle.
- Minimum pair period: SETTLE_CYCLES+3 cycles (A, B, settle window, one HOLD cycle).
- Backpressure: out_ready=0 stalls in HOLD indefinitely. Input is not accepted during the stall.
- pair_count wraps from 2^CNT_W-1 to 0 without any flag.
- Deassertion of rst takes effect at the next rising edge. in_ready rises one cycle after rst is high.

## Structure

- Shared package/include `int_apx_pkg`:
  - state encoding localparams ST_GET_A=2'd0, ST_GET_B=2'd1, ST_SETTLE=2'd2, ST_HOLD=2'd3
  - default DATA_PATH_BITWIDTH
- Settle counter width: $clog2(SETTLE_CYCLES+1), local to the block.
- Single module; no sub-module needed.
- Integration wrapper `int_add_seq_top` instantiates this block plus `config_int_add_clkGate`; it is not part of this block.

## Test plan

- Reset: hold rst=0 for 10 cycles with in_valid=1 -> in_ready, out_valid, add_reg_en, pair_count all 0; in_ready=1 one cycle after release.
- Basic pair, SETTLE_CYCLES=4, out_ready=1, reference adder attached:
  - stimulus: words 0x00000005 then 0xFFFFFFFD
  - add_reg_en high for exactly 4 cycles
  - out_valid one cycle later with out_a=5, out_b=0xFFFFFFFD, out_c=expected adder result (2 for exact)
  - pair_count=1
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_* stable and in_ready=0 throughout; on out_ready=1, handshake in that cycle and in_ready=1 in the next.
- Back-to-back, in_valid=1 continuously, 8 pairs -> exactly 8 output triples in order, pair period = SETTLE_CYCLES+3, add_a/add_b never change while add_reg_en=1.
- Mid-operation reset: assert rst=0 during SETTLE cycle 2 -> no out_valid, add_reg_en=0 immediately, next pair after release processed normally.
- Wrap, CNT_W=4, 17 pairs -> pair_count reads 0 after 16 handshakes and 1 after the 17th.
